// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered, valid/ready handshaked ALU-control decoder.
// Decodes a MIPS subset from instr[31:26]/[5:0] into an ALU code and operand
// flags. MULT/DIV hold the block for MD_LATENCY extra cycles before the
// decoded result is presented.
// Optional feature macro: ALUCTRL_ILLEGAL_TRAP_EN (sticky trap on illegal
// instructions, adds trap_clr/trap ports). Default build leaves it disabled.
module alu_ctrl_pipe #(
   parameter int CTRL_W     = 4,
   parameter int MD_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] alu_ctr,
   output logic              use_imm,
   output logic              zero_ext,
   output logic              illegal,
   output logic              md_busy
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
   ,
   input  logic              trap_clr,
   output logic              trap
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_MD    = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] code;
      logic       use_imm;
      logic       zero_ext;
      logic       illegal;
      logic       is_md;
   } dec_t;

   // Pure opcode/function decode; the result is registered by the caller.
   function automatic dec_t decode(input logic [5:0] op, input logic [5:0] func);
      dec_t d;
      d.code     = 4'h0;
      d.use_imm  = 1'b0;
      d.zero_ext = 1'b0;
      d.illegal  = 1'b0;
      d.is_md    = 1'b0;
      case (op)
         6'b000000: begin
            case (func)
               6'b100000, 6'b100001: d.code = 4'h0;
               6'b100010, 6'b100011: d.code = 4'h1;
               6'b100100:            d.code = 4'h2;
               6'b100101:            d.code = 4'h3;
               6'b100110:            d.code = 4'h5;
               6'b100111:            d.code = 4'h6;
               6'b101010:            d.code = 4'h4;
               6'b000000:            d.code = 4'h7;
               6'b000010:            d.code = 4'h8;
               6'b000011:            d.code = 4'h9;
               6'b011000: begin
                  d.code  = 4'hB;
                  d.is_md = 1'b1;
               end
               6'b011010: begin
                  d.code  = 4'hC;
                  d.is_md = 1'b1;
               end
               default: begin
                  d.code    = 4'hE;
                  d.illegal = 1'b1;
               end
            endcase
         end
         6'b100011, 6'b101011, 6'b001000: begin
            d.code    = 4'h0;
            d.use_imm = 1'b1;
         end
         6'b000100, 6'b000101: d.code = 4'h1;
         6'b001100: begin
            d.code     = 4'h2;
            d.use_imm  = 1'b1;
            d.zero_ext = 1'b1;
         end
         6'b001101: begin
            d.code     = 4'h3;
            d.use_imm  = 1'b1;
            d.zero_ext = 1'b1;
         end
         6'b001110: begin
            d.code     = 4'h5;
            d.use_imm  = 1'b1;
            d.zero_ext = 1'b1;
         end
         6'b001010: begin
            d.code    = 4'h4;
            d.use_imm = 1'b1;
         end
         6'b001111: begin
            d.code    = 4'hA;
            d.use_imm = 1'b1;
         end
         default: begin
            d.code    = 4'hF;
            d.illegal = 1'b1;
         end
      endcase
      return d;
   endfunction

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [CTRL_W-1:0] alu_ctr_q, alu_ctr_d;
   logic              use_imm_q, use_imm_d;
   logic              zero_ext_q, zero_ext_d;
   logic              illegal_q, illegal_d;
   logic              trap_q, trap_d;
   logic              accept_s;
   dec_t              dec_s;

   // Register-field bits between opcode and function do not affect control.
   logic [19:0]       unused_instr_bits;
   assign unused_instr_bits = instr[25:6];

   assign dec_s = decode(instr[31:26], instr[5:0]);

   // Ready depends on state, consumer backpressure and the sticky trap.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_EMPTY: in_ready = ~trap_q;
         ST_FULL:  in_ready = out_ready & ~trap_q;
         ST_MD:    in_ready = 1'b0;
         default:  in_ready = 1'b0;
      endcase
   end

   assign accept_s = in_valid & in_ready;

   // Next-state, counter and decoded-field load logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      alu_ctr_d  = alu_ctr_q;
      use_imm_d  = use_imm_q;
      zero_ext_d = zero_ext_q;
      illegal_d  = illegal_q;
      if (accept_s) begin
         // A new instruction always replaces whatever was held.
         alu_ctr_d  = CTRL_W'(dec_s.code);
         use_imm_d  = dec_s.use_imm;
         zero_ext_d = dec_s.zero_ext;
         illegal_d  = dec_s.illegal;
         if (dec_s.is_md) begin
            state_d = ST_MD;
            cnt_d   = 8'(MD_LATENCY - 1);
         end else begin
            state_d = ST_FULL;
            cnt_d   = cnt_q;
         end
      end else begin
         case (state_q)
            ST_EMPTY: state_d = ST_EMPTY;
            ST_FULL: begin
               if (out_ready) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_FULL;
               end
            end
            ST_MD: begin
               if (cnt_q == 8'd0) begin
                  state_d = ST_FULL;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
   // Sticky trap: set on accepting an illegal instr, cleared by trap_clr.
   always_comb begin
      trap_d = trap_q;
      if (accept_s && dec_s.illegal) begin
         trap_d = 1'b1;
      end else if (trap_clr) begin
         trap_d = 1'b0;
      end else begin
         trap_d = trap_q;
      end
   end
   assign trap = trap_q;
`else
   // Without the trap feature illegal instrs simply flow through.
   always_comb begin
      trap_d = 1'b0;
   end
`endif

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         cnt_q      <= 8'd0;
         alu_ctr_q  <= '0;
         use_imm_q  <= 1'b0;
         zero_ext_q <= 1'b0;
         illegal_q  <= 1'b0;
         trap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         alu_ctr_q  <= alu_ctr_d;
         use_imm_q  <= use_imm_d;
         zero_ext_q <= zero_ext_d;
         illegal_q  <= illegal_d;
         trap_q     <= trap_d;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign md_busy   = (state_q == ST_MD);
   assign alu_ctr   = alu_ctr_q;
   assign use_imm   = use_imm_q;
   assign zero_ext  = zero_ext_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed testbench for alu_ctrl_pipe with hand-computed expected values.
module tb_alu_ctrl_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_ctr;
   logic        use_imm;
   logic        zero_ext;
   logic        illegal;
   logic        md_busy;
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
   logic        trap_clr;
   logic        trap;
`endif

   int n_vectors;
   int n_miscompares;

   alu_ctrl_pipe #(.CTRL_W(4), .MD_LATENCY(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
      .alu_ctr(alu_ctr), .use_imm(use_imm), .zero_ext(zero_ext),
      .illegal(illegal), .md_busy(md_busy)
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
      , .trap_clr(trap_clr), .trap(trap)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vectors++;
      if (obs !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check a valid result beat.
   task automatic check_beat(input string tag, input logic [3:0] code,
                             input logic imm, input logic zx, input logic ill);
      check_eq({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      check_eq({tag, ".alu"}, {28'd0, alu_ctr}, {28'd0, code});
      check_eq({tag, ".imm"}, {31'd0, use_imm}, {31'd0, imm});
      check_eq({tag, ".zext"}, {31'd0, zero_ext}, {31'd0, zx});
      check_eq({tag, ".ill"}, {31'd0, illegal}, {31'd0, ill});
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  code;
      logic        imm;
      logic        zx;
   } vec_t;

   vec_t tbl[10];

   initial begin
      n_vectors     = 0;
      n_miscompares = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      instr     = 32'd0;
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
      trap_clr  = 1'b0;
`endif
      tbl[0] = '{32'h30220001, 4'h2, 1'b1, 1'b1};  // andi
      tbl[1] = '{32'h38220001, 4'h5, 1'b1, 1'b1};  // xori
      tbl[2] = '{32'h28220001, 4'h4, 1'b1, 1'b0};  // slti
      tbl[3] = '{32'h3C010001, 4'hA, 1'b1, 1'b0};  // lui
      tbl[4] = '{32'h00011843, 4'h9, 1'b0, 1'b0};  // sra
      tbl[5] = '{32'h00221827, 4'h6, 1'b0, 1'b0};  // nor
      tbl[6] = '{32'h00011840, 4'h7, 1'b0, 1'b0};  // sll
      tbl[7] = '{32'hAC220004, 4'h0, 1'b1, 1'b0};  // sw
      tbl[8] = '{32'h14220003, 4'h1, 1'b0, 1'b0};  // bne
      tbl[9] = '{32'h00221823, 4'h1, 1'b0, 1'b0};  // subu

      // Reset values.
      #12;
      check_eq("rst.valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst.ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst.alu", {28'd0, alu_ctr}, 32'd0);
      check_eq("rst.flags", {28'd0, use_imm, zero_ext, illegal, md_busy}, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("idle.valid", {31'd0, out_valid}, 32'd0);
         check_eq("idle.ready", {31'd0, in_ready}, 32'd1);
      end

      // Back-to-back stream, no bubbles.
      in_valid = 1'b1;
      instr = 32'h00221820;
      tick();
      check_beat("add", 4'h0, 1'b0, 1'b0, 1'b0);
      check_eq("add.ready", {31'd0, in_ready}, 32'd1);
      instr = 32'h34220005;
      tick();
      check_beat("ori", 4'h3, 1'b1, 1'b1, 1'b0);
      instr = 32'h10220003;
      tick();
      check_beat("beq", 4'h1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         instr = tbl[i].ins;
         tick();
         check_beat($sformatf("tbl%0d", i), tbl[i].code, tbl[i].imm, tbl[i].zx, 1'b0);
      end
      in_valid = 1'b0;
      tick();
      check_eq("drain.valid", {31'd0, out_valid}, 32'd0);

      // Backpressure holds the lw result and stalls input.
      out_ready = 1'b0;
      in_valid = 1'b1;
      instr = 32'h8C220004;
      tick();
      instr = 32'h34220005;
      for (int i = 0; i < 2; i++) begin
         check_beat("lw_hold", 4'h0, 1'b1, 1'b0, 1'b0);
         check_eq("stall.ready", {31'd0, in_ready}, 32'd0);
         tick();
      end
      check_beat("lw_hold", 4'h0, 1'b1, 1'b0, 1'b0);
      out_ready = 1'b1;
      #1;
      check_eq("release.ready", {31'd0, in_ready}, 32'd1);
      tick();
      check_beat("ori_after", 4'h3, 1'b1, 1'b1, 1'b0);
      in_valid = 1'b0;
      tick();

      // MULT then DIV: busy for 4 cycles, then the result.
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         instr = (k == 0) ? 32'h00220018 : 32'h0022001A;
         tick();
         in_valid = 1'b0;
         for (int i = 0; i < 4; i++) begin
            check_eq("md.busy", {31'd0, md_busy}, 32'd1);
            check_eq("md.ready", {31'd0, in_ready}, 32'd0);
            check_eq("md.valid", {31'd0, out_valid}, 32'd0);
            tick();
         end
         check_beat("md_done", (k == 0) ? 4'hB : 4'hC, 1'b0, 1'b0, 1'b0);
         check_eq("md_done.busy", {31'd0, md_busy}, 32'd0);
         tick();
      end

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
      // Illegal instr sets the sticky trap and stalls until cleared.
      in_valid = 1'b1;
      instr = 32'h0000003F;
      tick();
      check_beat("ill_func", 4'hE, 1'b0, 1'b0, 1'b1);
      check_eq("trap.set", {31'd0, trap}, 32'd1);
      check_eq("trap.ready", {31'd0, in_ready}, 32'd0);
      instr = 32'h00221820;
      tick();
      check_eq("trap.drained", {31'd0, out_valid}, 32'd0);
      check_eq("trap.stall", {31'd0, in_ready}, 32'd0);
      trap_clr = 1'b1;
      tick();
      trap_clr = 1'b0;
      check_eq("trap.clr", {31'd0, trap}, 32'd0);
      check_eq("trap.ready2", {31'd0, in_ready}, 32'd1);
      tick();
      check_beat("post_trap", 4'h0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      tick();
`else
      // Illegal instrs pass through with illegal=1 for their beat only.
      in_valid = 1'b1;
      instr = 32'h0000003F;
      tick();
      check_beat("ill_func", 4'hE, 1'b0, 1'b0, 1'b1);
      instr = 32'hFC000000;
      tick();
      check_beat("ill_op", 4'hF, 1'b0, 1'b0, 1'b1);
      instr = 32'h00221820;
      tick();
      check_beat("post_ill", 4'h0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      tick();
`endif

      // Reset in the middle of a MULT wait.
      in_valid = 1'b1;
      instr = 32'h00220018;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check_eq("mid.busy_pre", {31'd0, md_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("mid.busy", {31'd0, md_busy}, 32'd0);
      check_eq("mid.valid", {31'd0, out_valid}, 32'd0);
      check_eq("mid.ready", {31'd0, in_ready}, 32'd1);
      #2;
      rst_n = 1'b1;
      in_valid = 1'b1;
      instr = 32'h34220005;
      tick();
      check_beat("after_rst", 4'h3, 1'b1, 1'b1, 1'b0);
      in_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
